mem_loader: RTL

MEM_LOADER -- requirements
Module: mem_loader

---
 rtl/mem_loader_pkg.sv | 14 +
 rtl/mem_loader.sv | 111 +++++++++++
 2 files changed

// File: rtl/mem_loader_pkg.sv
// Shared definitions for mem_loader: FSM state encoding and default geometry.
package mem_loader_pkg;

  localparam int DEFAULT_DEPTH = 64;
  localparam int DEFAULT_AW    = 6;
  localparam int DEFAULT_DW    = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

endpackage

// File: rtl/mem_loader.sv
// Frame loader: streams DEPTH words into a memory, then enables a downstream mover.
// Optional running checksum of loaded words when MEM_LOADER_CHECKSUM_EN is defined.
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = DEFAULT_AW,
  parameter int DW    = DEFAULT_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          go,
  input  logic          abort,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          cs,
  output logic          rw_,
  output logic [AW-1:0] adder,
  output logic [DW-1:0] datain,
  output logic          start,
  input  logic          done_in,
  output logic          busy,
  output logic          finished,
  output logic [AW:0]   load_cnt,
  output logic [DW-1:0] checksum
);

  localparam logic [AW:0] LAST_IDX = (AW+1)'(DEPTH - 1);

  state_t state, state_next;
  logic   write;       // accepted beat that actually reaches the memory
  logic   enter_load;
  logic   run_done;

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    write      = 1'b0;
    enter_load = 1'b0;
    run_done   = 1'b0;

    unique case (state)
      IDLE: begin
        if (go) begin
          state_next = LOAD;
          enter_load = 1'b1;
        end
      end
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          write = 1'b1;
          if (load_cnt == LAST_IDX) state_next = RUN;
        end
      end
      RUN: begin
        if (done_in) begin
          state_next = IDLE;
          run_done   = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    // Abort outranks beat, go and done_in, and kills the write of this cycle.
    if (abort) begin
      state_next = IDLE;
      write      = 1'b0;
      enter_load = 1'b0;
      run_done   = 1'b0;
    end
  end

  // Write port is gated so nothing leaks onto the memory bus without a write.
  assign cs     = write;
  assign rw_    = ~write;
  assign adder  = write ? load_cnt[AW-1:0] : '0;
  assign datain = write ? in_data : '0;

  assign start  = (state == RUN);
  assign busy   = (state != IDLE);

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      load_cnt <= '0;
      finished <= 1'b0;
    end else begin
      state    <= state_next;
      finished <= run_done;
      if (enter_load)  load_cnt <= '0;
      else if (write)  load_cnt <= load_cnt + 1'b1;
    end
  end

`ifdef MEM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          checksum <= '0;
    else if (enter_load) checksum <= '0;
    else if (write)      checksum <= checksum + in_data;
  end
`else
  assign checksum = '0;
`endif

endmodule
